// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// pipeline_ctrl_pkg : shared stall encodings, exception defaults, FSM states
// Revision: 1.0
// ============================================================================
package pipeline_ctrl_pkg;

    localparam logic STOP   = 1'b1;
    localparam logic NOSTOP = 1'b0;

    localparam int STALL_W = 6;

    // Bit order is {WB, MEM, EX, ID, IF, PC}; a request stops its own stage and all earlier ones.
    localparam logic [STALL_W-1:0] STALL_NONE = {6{NOSTOP}};
    localparam logic [STALL_W-1:0] STALL_IF   = {{4{NOSTOP}}, {2{STOP}}};
    localparam logic [STALL_W-1:0] STALL_ID   = {{3{NOSTOP}}, {3{STOP}}};
    localparam logic [STALL_W-1:0] STALL_EX   = {{2{NOSTOP}}, {4{STOP}}};
    localparam logic [STALL_W-1:0] STALL_MEM  = {NOSTOP, {5{STOP}}};

    localparam logic [31:0] EXC_VECTOR_DEF = 32'h0000_0020;
    localparam logic [31:0] ERET_CODE_DEF  = 32'h0000_000e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    function automatic logic [31:0] redirect_pc(
        input logic [31:0] exc,
        input logic [31:0] epc,
        input logic [31:0] eret_code,
        input logic [31:0] vector
    );
        return (exc == eret_code) ? epc : vector;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// sat_counter : saturating up-counter with synchronous active-low clear
// Revision: 1.0
// ============================================================================
module sat_counter #(
    parameter int              WIDTH = 16,
    parameter logic [WIDTH-1:0] MAX  = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst || !clr_n) begin
            r_count <= '0;
        end else if (inc && (r_count != MAX)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// pipeline_ctrl : stall merge, exception flush/redirect, stall statistics
// Revision: 1.0
// ============================================================================
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEF,
    parameter logic [31:0] ERET_CODE  = ERET_CODE_DEF,
    parameter int          WDOG_MAX   = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stallreq_from_if,
    input  logic               stallreq_from_id,
    input  logic               stallreq_from_ex,
    input  logic               stallreq_from_mem,
    input  logic [31:0]        excepttype_i,
    input  logic [31:0]        cp0_epc_i,
    output logic [STALL_W-1:0] stall,
    output logic               flush,
    output logic [31:0]        new_pc,
    output logic               stall_timeout,
    output logic [31:0]        stall_cycles,
    output logic [15:0]        flush_count
);

    localparam int              WD_W    = $clog2(WDOG_MAX + 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(WDOG_MAX);
    localparam logic [WD_W-1:0] WD_TRIP = WD_W'(WDOG_MAX - 1);

    state_t           r_state;
    logic [31:0]      r_pend_exc;
    logic [31:0]      r_pend_epc;
    logic             r_timeout;
    logic [WD_W-1:0]  w_wdog;
    logic [STALL_W-1:0] w_req;
    logic             w_exc;
    logic             w_stall_any;

    assign w_exc = (excepttype_i != 32'h0);

    always_comb begin
        if (stallreq_from_mem)     w_req = STALL_MEM;
        else if (stallreq_from_ex) w_req = STALL_EX;
        else if (stallreq_from_id) w_req = STALL_ID;
        else if (stallreq_from_if) w_req = STALL_IF;
        else                       w_req = STALL_NONE;
    end

    // Flush always wins over stall; all outputs are forced quiet while reset is asserted.
    always_comb begin
        stall  = STALL_NONE;
        flush  = 1'b0;
        new_pc = 32'h0;
        if (rst) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_exc && !stallreq_from_mem) begin
                        flush  = 1'b1;
                        new_pc = redirect_pc(excepttype_i, cp0_epc_i, ERET_CODE, EXC_VECTOR);
                    end else begin
                        stall = w_req;
                    end
                end
                ST_PEND: begin
                    if (stallreq_from_mem) begin
                        stall = STALL_MEM;
                    end else begin
                        flush  = 1'b1;
                        new_pc = redirect_pc(r_pend_exc, r_pend_epc, ERET_CODE, EXC_VECTOR);
                    end
                end
                default: ;
            endcase
        end
    end

    assign w_stall_any = (stall != STALL_NONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_pend_exc <= 32'h0;
            r_pend_epc <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_exc && stallreq_from_mem) begin
                        r_pend_exc <= excepttype_i;
                        r_pend_epc <= cp0_epc_i;
                        r_state    <= ST_PEND;
                    end
                end
                ST_PEND: begin
                    if (!stallreq_from_mem) begin
                        r_pend_exc <= 32'h0;
                        r_pend_epc <= 32'h0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Trip on the edge that brings the run of stalled cycles up to WDOG_MAX.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_timeout <= 1'b0;
        end else if (w_stall_any && (w_wdog >= WD_TRIP)) begin
            r_timeout <= 1'b1;
        end
    end

    assign stall_timeout = r_timeout;

    sat_counter #(.WIDTH(WD_W), .MAX(WD_MAX)) u_watchdog (
        .clk   (clk),
        .rst   (rst),
        .clr_n (w_stall_any),
        .inc   (w_stall_any),
        .count (w_wdog)
    );

    sat_counter #(.WIDTH(32), .MAX(32'hFFFF_FFFF)) u_stall_cycles (
        .clk   (clk),
        .rst   (rst),
        .clr_n (1'b1),
        .inc   (w_stall_any),
        .count (stall_cycles)
    );

    sat_counter #(.WIDTH(16), .MAX(16'hFFFF)) u_flush_count (
        .clk   (clk),
        .rst   (rst),
        .clr_n (1'b1),
        .inc   (flush),
        .count (flush_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pipeline_ctrl : directed stimulus, cycle-level reference model, literal pins
// Revision: 1.0
// ============================================================================
module tb_pipeline_ctrl;

    localparam int WDOG = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_if, req_id, req_ex, req_mem;
    logic [31:0] exc, epc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic        stall_timeout;
    logic [31:0] stall_cycles;
    logic [15:0] flush_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(.EXC_VECTOR(32'h20), .ERET_CODE(32'he), .WDOG_MAX(WDOG)) dut (
        .clk               (clk),
        .rst               (rst),
        .stallreq_from_if  (req_if),
        .stallreq_from_id  (req_id),
        .stallreq_from_ex  (req_ex),
        .stallreq_from_mem (req_mem),
        .excepttype_i      (exc),
        .cp0_epc_i         (epc),
        .stall             (stall),
        .flush             (flush),
        .new_pc            (new_pc),
        .stall_timeout     (stall_timeout),
        .stall_cycles      (stall_cycles),
        .flush_count       (flush_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an exception "owed" to the pipeline plus running statistics.
    logic        m_valid = 1'b0;
    logic        m_owed;
    logic [31:0] m_exc, m_epc;
    logic [31:0] m_sc;
    logic [15:0] m_fc;
    int          m_run;
    logic        m_to;

    function automatic logic [31:0] target(input logic [31:0] e, input logic [31:0] p);
        return (e == 32'he) ? p : 32'h20;
    endfunction

    function automatic void expect_out(output logic [5:0] s, output logic f, output logic [31:0] pc);
        int n;
        s = 6'd0; f = 1'b0; pc = 32'd0;
        if (rst) begin
            if (m_owed && !req_mem) begin
                f = 1'b1; pc = target(m_exc, m_epc);
            end else if (!m_owed && exc != 0 && !req_mem) begin
                f = 1'b1; pc = target(exc, epc);
            end else begin
                n = req_mem ? 5 : req_ex ? 4 : req_id ? 3 : req_if ? 2 : 0;
                s = 6'((1 << n) - 1);
            end
        end
    endfunction

    always @(posedge clk) begin
        logic [5:0]  s;
        logic        f;
        logic [31:0] pc;
        if (!rst) begin
            m_valid = 1'b1; m_owed = 1'b0; m_exc = 0; m_epc = 0;
            m_sc = 0; m_fc = 0; m_run = 0; m_to = 1'b0;
        end else if (m_valid) begin
            expect_out(s, f, pc);
            if (s != 0) begin
                if (m_sc != 32'hFFFFFFFF) m_sc++;
                if (m_run < WDOG) m_run++;
            end else begin
                m_run = 0;
            end
            if (m_run >= WDOG) m_to = 1'b1;
            if (f && m_fc != 16'hFFFF) m_fc++;
            if (m_owed && !req_mem) m_owed = 1'b0;
            else if (!m_owed && exc != 0 && req_mem) begin
                m_owed = 1'b1; m_exc = exc; m_epc = epc;
            end
        end
    end

    always @(negedge clk) begin
        logic [5:0]  s;
        logic        f;
        logic [31:0] pc;
        if (m_valid) begin
            expect_out(s, f, pc);
            chk("model_stall", 32'(stall), 32'(s));
            chk("model_flush", 32'(flush), 32'(f));
            chk("model_new_pc", new_pc, pc);
            chk("model_stall_cycles", stall_cycles, m_sc);
            chk("model_flush_count", 32'(flush_count), 32'(m_fc));
            chk("model_timeout", 32'(stall_timeout), 32'(m_to));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        req_if = 0; req_id = 0; req_ex = 0; req_mem = 0; exc = 0; epc = 0;
    endtask

    initial begin
        rst = 1'b0;
        idle_in();
        cyc(); cyc();
        @(negedge clk);
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_flush", 32'(flush), 32'h0);
        chk("rst_new_pc", new_pc, 32'h0);
        chk("rst_stall_cycles", stall_cycles, 32'h0);
        chk("rst_flush_count", 32'(flush_count), 32'h0);
        chk("rst_timeout", 32'(stall_timeout), 32'h0);
        cyc(); rst = 1'b1;

        req_id = 1; req_ex = 1;
        @(negedge clk); chk("prio_id_ex", 32'(stall), 32'h0f);
        cyc(); req_mem = 1;
        @(negedge clk); chk("prio_mem", 32'(stall), 32'h1f);
        cyc(); idle_in(); req_if = 1;
        @(negedge clk); chk("prio_if", 32'(stall), 32'h03);
        cyc(); idle_in();
        @(negedge clk); chk("prio_none", 32'(stall), 32'h00);

        cyc(); exc = 32'h8; req_id = 1;
        @(negedge clk);
        chk("imm_flush", 32'(flush), 32'h1);
        chk("imm_stall", 32'(stall), 32'h0);
        chk("imm_new_pc", new_pc, 32'h20);
        cyc(); idle_in();
        @(negedge clk);
        chk("imm_flush_off", 32'(flush), 32'h0);
        chk("imm_flush_count", 32'(flush_count), 32'h1);

        cyc(); exc = 32'he; epc = 32'h1234;
        @(negedge clk);
        chk("eret_flush", 32'(flush), 32'h1);
        chk("eret_new_pc", new_pc, 32'h1234);
        cyc(); idle_in();

        exc = 32'h8; epc = 32'h5555; req_mem = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("def_stall", 32'(stall), 32'h1f);
            chk("def_flush", 32'(flush), 32'h0);
            cyc();
            exc = (i == 1) ? 32'he : 32'h0;
            epc = 32'h9999;
            req_ex = 1;
        end
        req_mem = 0; exc = 0;
        @(negedge clk);
        chk("def_flush_now", 32'(flush), 32'h1);
        chk("def_stall_now", 32'(stall), 32'h0);
        chk("def_new_pc", new_pc, 32'h20);
        cyc(); idle_in();
        @(negedge clk);
        chk("def_single_pulse", 32'(flush), 32'h0);
        chk("def_flush_count", 32'(flush_count), 32'h3);

        cyc(); rst = 1'b0;
        cyc(); rst = 1'b1;
        for (int i = 0; i < 7; i++) begin
            req_ex = 1; cyc();
        end
        req_ex = 0;
        @(negedge clk); chk("wd_first_window", 32'(stall_timeout), 32'h0);
        cyc();
        for (int i = 0; i < 8; i++) begin
            req_ex = 1;
            @(negedge clk);
            if (i == 7) chk("wd_before_8th", 32'(stall_timeout), 32'h0);
            cyc();
        end
        req_ex = 0;
        @(negedge clk);
        chk("wd_set", 32'(stall_timeout), 32'h1);
        chk("wd_stall_cycles", stall_cycles, 32'd15);
        cyc(); cyc();
        @(negedge clk); chk("wd_sticky", 32'(stall_timeout), 32'h1);

        cyc(); exc = 32'h8; req_mem = 1;
        cyc(); exc = 0; rst = 1'b0;
        @(negedge clk); chk("rstpend_quiet", 32'(stall), 32'h0);
        cyc(); rst = 1'b1;
        @(negedge clk);
        chk("rstpend_stall", 32'(stall), 32'h1f);
        chk("rstpend_stall_cycles", stall_cycles, 32'h0);
        chk("rstpend_timeout", 32'(stall_timeout), 32'h0);
        cyc(); req_mem = 0;
        @(negedge clk); chk("rstpend_no_flush", 32'(flush), 32'h0);
        cyc();
        @(negedge clk);
        chk("rstpend_no_flush2", 32'(flush), 32'h0);
        chk("rstpend_flush_count", 32'(flush_count), 32'h0);

        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central pipeline control unit for the 5-stage core.
- Merges per-stage stall requests into the 6-bit stall vector consumed by pc_reg, if_id, id_ex, ex_mem and mem_wb.
- Generates the pipeline flush and redirect PC on exceptions and ERET, and holds an exception pending while the memory stage is stalled.
- Keeps stall/flush statistics and a stall watchdog for debug.

Parameters:
- EXC_VECTOR, 32'h00000020, redirect PC for all exceptions other than ERET.
- ERET_CODE, 32'h0000000e, excepttype value meaning ERET (redirect to cp0_epc).
- WDOG_MAX, 1024, consecutive stalled cycles before stall_timeout sets.

Ports:
- clk  in  1  clock, all state updates on posedge.
- rst  in  1  synchronous, active-low reset (rst==0 at posedge resets).
- stallreq_from_if  in  1  fetch-side stall request (instruction bus wait).
- stallreq_from_id  in  1  decode stall request (load-use hazard).
- stallreq_from_ex  in  1  execute stall request (multi-cycle div/madd).
- stallreq_from_mem  in  1  memory stall request (data bus wait).
- excepttype_i  in  32  exception code from MEM stage; 0 = none.
- cp0_epc_i  in  32  current EPC for ERET.
- stall  out  6  [0]=PC [1]=IF [2]=ID [3]=EX [4]=MEM [5]=WB; 1=Stop.
- flush  out  1  one-cycle pipeline flush.
- new_pc  out  32  redirect PC, valid while flush=1, else 0.
- stall_timeout  out  1  sticky watchdog flag.
- stall_cycles  out  32  saturating count of cycles with stall!=0.
- flush_count  out  16  saturating count of flush pulses.

Behaviour:
- Reset (rst==0 at posedge): state<=IDLE; pending regs<=0; counters<=0; stall_timeout<=0; watchdog<=0.
- Outputs are combinational from inputs and state, so during reset: stall=6'b000000, flush=0, new_pc=0.
- Stall encoding, highest stage wins:
  - mem: 6'b011111
  - ex: 6'b001111
  - id: 6'b000111
  - if: 6'b000011
  - none: 6'b000000
- Stall is combinational (same-cycle effect).
- FSM states: IDLE, PEND.
- IDLE, excepttype_i!=0 and stallreq_from_mem=0:
  - flush=1, stall=0 in the same cycle.
  - new_pc=cp0_epc_i if excepttype_i==ERET_CODE, else EXC_VECTOR.
  - Remain IDLE.
- IDLE, excepttype_i!=0 and stallreq_from_mem=1:
  - flush=0; stall=6'b011111.
  - Latch excepttype_i and cp0_epc_i into pending regs; go to PEND.
- PEND, stallreq_from_mem=1: stall=6'b011111, flush=0. All other requests and excepttype_i are ignored.
- PEND, stallreq_from_mem=0:
  - flush=1, stall=0, new_pc computed from the latched values. Live inputs are ignored.
  - Go to IDLE.
- flush overrides every stall request in its cycle.
- Exactly one flush pulse per exception; a flush is never issued for the same latched exception twice.
- Watchdog:
  - Increments each cycle with stall!=0; clears on any cycle with stall==0.
  - When it reaches WDOG_MAX, stall_timeout<=1 and stays 1 until reset. The counter saturates at WDOG_MAX.
- stall_cycles: +1 each cycle with stall!=0; saturates at 32'hFFFFFFFF.
- flush_count: +1 each cycle with flush=1; saturates at 16'hFFFF.
- Reset while in PEND drops the pending exception; no flush follows.

Decomposition:
- Shared defines file:
  - Stop/NoStop
  - the stall vector width
  - the four stall encodings
  - EXC_VECTOR/ERET_CODE defaults
  - the FSM state codes
- One natural sub-module: sat_counter (parameterised width, inc, sync active-low clear, saturate). Instantiated three times: watchdog, stall_cycles, flush_count.

Test Plan:
- Priority merge: stallreq_from_id=1 and stallreq_from_ex=1 → stall=6'b001111. Add stallreq_from_mem=1 → stall=6'b011111. All requests released → 6'b000000.
- Immediate exception: excepttype_i=32'h00000008, no mem stall, id stall=1 → same cycle flush=1, stall=0, new_pc=32'h00000020. Next cycle flush=0; flush_count=1.
- ERET: excepttype_i=32'h0000000e, cp0_epc_i=32'h00001234 → flush=1, new_pc=32'h00001234.
- Deferred exception:
  - Stimulus: excepttype_i=32'h00000008 with stallreq_from_mem=1 for 3 cycles. Change cp0_epc_i and clear excepttype_i during those cycles.
  - Response: stall=6'b011111 and flush=0 for 3 cycles. On the first cycle with mem=0, flush=1 and new_pc=32'h00000020 (from the latched values). A single pulse only.
- Watchdog (WDOG_MAX=8):
  - Hold stallreq_from_ex=1 for 7 cycles, release 1 cycle, then hold 8 cycles.
  - stall_timeout stays 0 through the first window and sets after the 8th consecutive stalled cycle.
  - It stays 1 after all requests drop; stall_cycles=15.
- Reset mid-PEND: enter PEND, then assert rst=0 for one posedge while mem stall continues → state IDLE, counters 0, and no flush after the mem stall drops.
